// File: rtl/model_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : model_share_arbiter
//  Purpose  : Lets NREQ requesters share one fixed-point model instance.
//             A requester is picked round-robin, its operands are registered
//             and held on model_a/model_b, the model is strobed once, and the
//             result is returned after MODEL_LATENCY cycles, tagged with the
//             requester id, over a valid/ready response channel. Only one
//             operation is in flight at a time.
//  Ports    : clk, rst_n         - clock, synchronous active-low reset
//             req_valid/ready    - per-requester request, one-hot accept
//             req_a/req_b        - packed operands, requester i in slice i
//             model_a/b/stb      - operands and evaluate strobe to the model
//             model_c            - model result
//             rsp_valid/ready    - response handshake
//             rsp_c/rsp_id       - captured result and served requester id
//             busy               - high whenever the FSM is not idle
//  Revision : 1.0  initial release
// ============================================================================
module model_share_arbiter #(
    parameter int NREQ          = 4,
    parameter int A_WIDTH       = 18,
    parameter int A_EXPONENT    = -12,
    parameter int B_WIDTH       = 18,
    parameter int B_EXPONENT    = -8,
    parameter int C_WIDTH       = 18,
    parameter int MODEL_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*A_WIDTH-1:0]   req_a,
    input  logic [NREQ*B_WIDTH-1:0]   req_b,
    output logic [A_WIDTH-1:0]        model_a,
    output logic [B_WIDTH-1:0]        model_b,
    output logic                      model_stb,
    input  logic [C_WIDTH-1:0]        model_c,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_WIDTH-1:0]        rsp_c,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      busy
);

    localparam int c_ID_W     = $clog2(NREQ);
    localparam int c_CNT_W    = (MODEL_LATENCY > 1) ? $clog2(MODEL_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(MODEL_LATENCY - 1);

    // The exponents only document the fixed-point formats; they are checked
    // here for sanity so a wildly wrong instantiation is caught at elaboration.
    generate
        if (NREQ < 2 || NREQ > 16 || MODEL_LATENCY < 1 ||
            A_EXPONENT < -256 || A_EXPONENT > 256 ||
            B_EXPONENT < -256 || B_EXPONENT > 256) begin : g_bad_params
            $error("model_share_arbiter: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_ID_W-1:0]      r_rr_ptr;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [A_WIDTH-1:0]     r_model_a;
    logic [B_WIDTH-1:0]     r_model_b;
    logic [C_WIDTH-1:0]     r_rsp_c;
    logic [c_ID_W-1:0]      r_rsp_id;

    logic                   w_grant_found;
    logic [c_ID_W-1:0]      w_grant_id;
    logic [c_ID_W:0]        w_idx_ext;
    logic [c_ID_W-1:0]      w_rr_next;

    // Round-robin search starting at r_rr_ptr. The loop runs from the far
    // end back toward the pointer so the last hit written is the closest one,
    // giving priority without needing an early exit.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_idx_ext     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx_ext = {1'b0, r_rr_ptr} + (c_ID_W + 1)'(k);
            if (w_idx_ext >= (c_ID_W + 1)'(NREQ)) begin
                w_idx_ext = w_idx_ext - (c_ID_W + 1)'(NREQ);
            end
            if (req_valid[w_idx_ext[c_ID_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_idx_ext[c_ID_W-1:0];
            end
        end
    end

    assign w_rr_next = (w_grant_id == c_ID_W'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;

    // Accept pulse is suppressed while reset is asserted so nothing looks
    // accepted on an edge that will not actually take the request.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_grant_found) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_found) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_cnt     <= '0;
            r_model_a <= '0;
            r_model_b <= '0;
            r_rsp_c   <= '0;
            r_rsp_id  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_found) begin
                        r_model_a <= req_a[w_grant_id*A_WIDTH +: A_WIDTH];
                        r_model_b <= req_b[w_grant_id*B_WIDTH +: B_WIDTH];
                        r_rsp_id  <= w_grant_id;
                        r_rr_ptr  <= w_rr_next;
                    end
                end
                S_ISSUE: r_cnt <= c_LAT_LOAD;
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_c <= model_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign model_a   = r_model_a;
    assign model_b   = r_model_b;
    assign model_stb = (r_state == S_ISSUE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_c     = r_rsp_c;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_model_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_model_share_arbiter
//  Purpose  : Self-checking bench for model_share_arbiter. A transaction-level
//             model tracks each operation by its age since acceptance and is
//             compared against the DUT every cycle; directed scenarios add
//             hand-computed expectations on grant order, timing and data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_model_share_arbiter;

    localparam int NREQ = 4;
    localparam int A_W  = 18;
    localparam int B_W  = 18;
    localparam int C_W  = 18;
    localparam int LAT  = 2;
    localparam int ID_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*A_W-1:0]   req_a;
    logic [NREQ*B_W-1:0]   req_b;
    logic [A_W-1:0]        model_a;
    logic [B_W-1:0]        model_b;
    logic                  model_stb;
    logic [C_W-1:0]        model_c;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [C_W-1:0]        rsp_c;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;

    model_share_arbiter #(
        .NREQ(NREQ), .A_WIDTH(A_W), .A_EXPONENT(-12), .B_WIDTH(B_W),
        .B_EXPONENT(-8), .C_WIDTH(C_W), .MODEL_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .model_a(model_a), .model_b(model_b),
        .model_stb(model_stb), .model_c(model_c), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub model: c = a + b through two register stages (latency 2).
    logic [C_W-1:0] s1, s2;
    always_ff @(posedge clk) begin
        s1 <= C_W'(model_a + model_b);
        s2 <= s1;
    end
    assign model_c = s2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    function automatic int grant_of(input logic [NREQ-1:0] v, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // ---------------- transaction-level model ----------------
    bit              m_known  = 1'b0;
    bit              m_active = 1'b0;
    int              m_age    = 0;
    int              m_rr     = 0;
    int              m_id     = 0;
    logic [A_W-1:0]  m_ma     = '0;
    logic [B_W-1:0]  m_mb     = '0;
    logic [C_W-1:0]  m_rc     = '0;
    int              m_g;
    logic [NREQ-1:0] e_ready;

    // ---------------- observation logs ----------------
    int              acc_id[$];
    int              acc_cyc[$];
    int              hs_id[$];
    int              hs_cyc[$];
    int              rise_cyc = -1;
    int              rise_id  = -1;
    logic [C_W-1:0]  rise_c   = '0;
    int              stb_cyc  = -1;
    logic [A_W-1:0]  stb_a    = '0;
    bit              prev_rv  = 1'b0;
    int              obs_idx;

    always @(negedge clk) begin
        m_g = -1;
        if (m_known) begin
            m_g     = m_active ? -1 : grant_of(req_valid, m_rr);
            e_ready = '0;
            if (rst_n && m_g >= 0) e_ready[m_g] = 1'b1;
            chk("req_ready", req_ready, e_ready);
            chk("model_stb", model_stb, m_active && (m_age == 1));
            chk("rsp_valid", rsp_valid, m_active && (m_age >= LAT + 2));
            chk("busy",      busy,      m_active);
            chk("model_a",   model_a,   m_ma);
            chk("model_b",   model_b,   m_mb);
            chk("rsp_c",     rsp_c,     m_rc);
            chk("rsp_id",    rsp_id,    m_id);
        end

        if (rst_n === 1'b1) begin
            if (req_ready != '0) begin
                obs_idx = -1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_idx = i;
                acc_id.push_back(obs_idx);
                acc_cyc.push_back(cyc);
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                hs_id.push_back(int'(rsp_id));
                hs_cyc.push_back(cyc);
            end
            if (rsp_valid === 1'b1 && !prev_rv) begin
                rise_cyc = cyc;
                rise_id  = int'(rsp_id);
                rise_c   = rsp_c;
            end
            if (model_stb === 1'b1) begin
                stb_cyc = cyc;
                stb_a   = model_a;
            end
        end
        prev_rv = (rsp_valid === 1'b1);

        // Advance the model across the coming rising edge.
        if (rst_n === 1'b0) begin
            m_known  = 1'b1;
            m_active = 1'b0;
            m_age    = 0;
            m_rr     = 0;
            m_id     = 0;
            m_ma     = '0;
            m_mb     = '0;
            m_rc     = '0;
        end else if (m_known) begin
            if (!m_active) begin
                if (m_g >= 0) begin
                    m_active = 1'b1;
                    m_age    = 1;
                    m_id     = m_g;
                    m_ma     = req_a[m_g*A_W +: A_W];
                    m_mb     = req_b[m_g*B_W +: B_W];
                    m_rr     = (m_g + 1) % NREQ;
                end
            end else begin
                if (m_age == LAT + 1) m_rc = C_W'(m_ma + m_mb);
                if (m_age >= LAT + 2 && rsp_ready) m_active = 1'b0;
                else m_age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        req_a[i*A_W +: A_W] = a;
        req_b[i*B_W +: B_W] = b;
    endtask

    task automatic clear_logs();
        acc_id.delete();
        acc_cyc.delete();
        hs_id.delete();
        hs_cyc.delete();
        rise_cyc = -1;
        stb_cyc  = -1;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout(name);
    endtask

    task automatic wait_accepts(input int n, input int budget, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            sample();
            if (acc_id.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout(name);
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int t_acc;
    bit ok_w;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // 1: reset then idle
        repeat (3) drive_edge();
        rst_n = 1'b1;
        clear_logs();
        repeat (10) sample();
        chk("idle_no_accept", acc_id.size(), 0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_rsp_valid", rsp_valid, 1'b0);
        chk("idle_model_a", model_a, 0);

        // 2: single request on requester 2
        drive_edge();
        clear_logs();
        set_op(2, 18'h00A00, 18'h00640);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        wait_accepts(1, 20, "single_accept");
        t_acc = q_at(acc_cyc, 0);
        chk("single_grant_id", q_at(acc_id, 0), 2);
        drive_edge();
        req_valid = '0;
        wait_idle("single_idle");
        chk("single_stb_cycle", stb_cyc, t_acc + 1);
        chk("single_stb_a", stb_a, 18'h00A00);
        chk("single_rsp_cycle", rise_cyc, t_acc + 4);
        chk("single_rsp_id", rise_id, 2);
        chk("single_rsp_c", rise_c, 18'h01040);

        // 3: all requesters valid, starting from a fresh pointer
        drive_edge();
        rst_n = 1'b0;
        drive_edge();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 18'((i + 1) * 'h100), 18'((i + 1) * 'h10));
        clear_logs();
        req_valid = 4'b1111;
        wait_accepts(5, 60, "rr_accepts");
        drive_edge();
        req_valid = '0;
        wait_idle("rr_idle");
        for (int i = 0; i < 5; i++) chk("rr_order", q_at(acc_id, i), exp_order[i]);
        for (int i = 0; i < 4; i++) chk("rr_spacing", q_at(acc_cyc, i + 1) - q_at(acc_cyc, i), 5);
        for (int i = 0; i < 5; i++) chk("rr_rsp_id", q_at(hs_id, i), exp_order[i]);

        // 4: back-pressure; pointer now at 1
        drive_edge();
        clear_logs();
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        ok_w = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sample();
            if (rise_cyc >= 0) begin
                ok_w = 1'b1;
                break;
            end
        end
        if (!ok_w) fail_timeout("bp_rise");
        chk("bp_rise_id", rise_id, 1);
        chk("bp_rise_c", rise_c, 18'h00220);
        for (int k = 0; k < 7; k++) begin
            sample();
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_hold_id", rsp_id, 1);
            chk("bp_hold_c", rsp_c, 18'h00220);
            chk("bp_hold_no_ready", req_ready, 4'b0000);
            chk("bp_hold_no_stb", model_stb, 1'b0);
        end
        drive_edge();
        rsp_ready = 1'b1;
        sample();
        sample();
        chk("bp_next_grant", q_at(acc_id, 1), 3);
        chk("bp_next_gap", q_at(acc_cyc, 1) - q_at(hs_cyc, 0), 1);
        drive_edge();
        req_valid = '0;
        wait_idle("bp_idle");

        // 5: reset in the middle of an operation; pointer now at 0
        drive_edge();
        clear_logs();
        req_valid = 4'b0001;
        ok_w = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sample();
            if (stb_cyc >= 0) begin
                ok_w = 1'b1;
                break;
            end
        end
        if (!ok_w) fail_timeout("mid_reset_stb");
        drive_edge();
        rst_n     = 1'b0;
        req_valid = 4'b0010;
        sample();
        chk("mid_reset_held_ready", req_ready, 4'b0000);
        drive_edge();
        rst_n = 1'b1;
        sample();
        chk("mid_reset_rsp_valid", rsp_valid, 1'b0);
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_grant1", req_ready, 4'b0010);
        drive_edge();
        req_valid = '0;
        wait_idle("mid_reset_idle");
        chk("mid_reset_rsp_count", hs_id.size(), 1);
        chk("mid_reset_rsp_id", q_at(hs_id, 0), 1);

        // 6: requester 3 drops as requester 1 is granted
        drive_edge();
        clear_logs();
        rst_n     = 1'b0;
        req_valid = 4'b1000;
        sample();
        drive_edge();
        rst_n     = 1'b1;
        req_valid = 4'b0010;
        sample();
        chk("drop_only_ready1", req_ready, 4'b0010);
        drive_edge();
        req_valid = '0;
        wait_idle("drop_idle");
        repeat (5) sample();
        chk("drop_accept_count", acc_id.size(), 1);
        drive_edge();
        req_valid = 4'b1000;
        wait_accepts(2, 20, "drop_reassert");
        chk("drop_reassert_id", q_at(acc_id, 1), 3);
        drive_edge();
        req_valid = '0;
        wait_idle("drop_final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
